if_prefetch: RTL and testbench
==============================

// Module: if_prefetch
// PURPOSE
//  Instruction-fetch front end; consumes the jump/pause controls that the pipeline control block emits.
//  Owns the PC, issues pipelined word reads on the instruction bus and buffers returned words in a small FIFO.
//  Presents one instruction per cycle to the IF/ID register and flushes on jump.
//  Sits between the control block, instruction memory and if_id.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset
//  DEPTH     4              FIFO entries; power of 2, >=2; also the outstanding-read limit
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous, active-high reset
//  jump_flag_i    in   1   redirect request (`JumpEnable)
//  jump_addr_i    in   32  redirect target, word aligned
//  pause_flag_i   in   3   pipeline pause; any nonzero value (e.g. `Pause_Id) holds the output
//  ibus_req_o     out  1   read request
//  ibus_addr_o    out  32  read address
//  ibus_gnt_i     in   1   request accepted this cycle
//  ibus_rvalid_i  in   1   read data valid, in request order, >=1 cycle after gnt
//  ibus_rdata_i   in   32  read data
//  inst_valid_o   out  1   inst_o/inst_addr_o valid
//  inst_o         out  32  instruction; `INST_NOP when not valid
//  inst_addr_o    out  32  PC of inst_o
// BEHAVIOUR
//  Reset: pc=RESET_PC, FIFO empty, outstanding=0, discard=0; ibus_req_o=0, inst_valid_o=0, inst_o=`INST_NOP, inst_addr_o=0.
//  - First request is issued the cycle after rst deasserts.
//  Issue:
//  - ibus_req_o=1 when occupancy+outstanding < DEPTH and jump_flag_i=0.
//  - ibus_addr_o=pc, held stable until gnt.
//  - gnt: pc+=4 (wraps mod 2^32), outstanding++.
//  Return:
//  - rvalid with discard>0: word dropped, discard--.
//  - Otherwise {rdata, addr} is pushed into the FIFO; outstanding--. Addr comes from a parallel tag FIFO.
//  - Credit rule guarantees no push into a full FIFO; an overflow is an assertion failure.
//  Output:
//  - inst_valid_o = !empty & !jump_flag_i; head entry drives inst_o and inst_addr_o.
//  - Pop when inst_valid_o & pause_flag_i==0. With a nonzero pause the head is held unchanged.
//  - Empty FIFO: inst_o=`INST_NOP, valid=0; the pipeline inserts a bubble.
//  Jump (jump_flag_i=1, single-cycle):
//  - Same cycle: ibus_req_o=0, inst_valid_o=0.
//  - Next edge: pc=jump_addr_i, FIFO and tag FIFO cleared.
//  - discard = outstanding after this cycle's gnt/rvalid accounting: a grant in the jump cycle cannot occur (req=0), and an rvalid in the jump cycle is itself discarded.
//  - Request to the target is issued the following cycle; first target instruction is valid >=2 cycles after the jump.
//  Simultaneous push and pop: occupancy unchanged; a pop on a full FIFO frees a credit the next cycle.
//  Jump together with pause: jump wins, FIFO flushed regardless of pause.
//  rst mid-transfer: all state cleared. The bus must drop in-flight responses on rst.
// CONFIGURATION
//  IF_PREFETCH_PERF_EN defined:
//  - Adds outputs perf_starve_o[31:0] (cycles with empty FIFO and no pause) and perf_discard_o[31:0] (dropped responses).
//  - Both counters are saturating and reset to 0.
//  Undefined: these ports and counters are absent; all other behaviour identical.
// STRUCTURE
//  Shared defines.v: `JumpEnable, `Pause_Id, `INST_NOP (32'h0000_0013), `ZeroWord.
//  Sub-module if_fifo: sync FIFO, width and DEPTH parameterised, flush input. Instantiated once at 64 bits {addr,inst}.
//  Top level holds the PC, outstanding and discard counters, and the issue/credit logic.
// TESTING
//  1. Reset, RESET_PC=0, zero-wait memory (gnt=1, rvalid next cycle) -> inst_addr_o 0,4,8,... every cycle from cycle 2; req first at cycle 1.
//  2. pause_flag_i=3'b010 for 5 cycles -> inst_o/inst_addr_o frozen; FIFO fills to DEPTH then ibus_req_o=0; resumes in order, no loss or duplication.
//  3. Jump to 32'h100 with 2 reads outstanding -> both responses dropped (perf_discard_o=2 if enabled); next valid inst_addr_o=32'h100.
//  4. Jump while pause active and FIFO full -> FIFO flushed; after pause clears, first output is the target instruction.
//  5. Memory with random 0-3 cycle gnt/rvalid delays, 1000 cycles, no jumps -> inst_addr_o strictly +4 sequence; ibus_addr_o stable while req & !gnt.
//  6. rst asserted mid-burst -> next cycle inst_valid_o=0, ibus_req_o=0; refetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Holds the NOP encoding, the {addr, inst} FIFO entry and a saturating-increment helper.
package if_prefetch_pkg;

    localparam logic [31:0] INST_NOP   = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [2:0]  PAUSE_NONE = 3'b000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Instruction bus between the prefetcher (master) and instruction memory (slave).
// Pipelined reads: req/addr held until gnt, rvalid/rdata return in request order.
interface if_prefetch_if;

    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;

    modport master (
        output ibus_req, ibus_addr,
        input  ibus_gnt, ibus_rvalid, ibus_rdata
    );

    modport slave (
        input  ibus_req, ibus_addr,
        output ibus_gnt, ibus_rvalid, ibus_rdata
    );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO with flush; width and power-of-two depth parameterised.
// Used by the prefetcher to buffer {addr, inst} words returned from the bus.
module if_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;

    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (i_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!i_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (i_push && !i_flush) |-> (r_count != FULL_CNT));

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the PC, issues credit-limited pipelined reads, buffers words.
// Define IF_PREFETCH_PERF_EN to add the saturating starve/discard performance counters.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 jump_flag_i,
    input  logic [31:0]          jump_addr_i,
    input  logic [2:0]           pause_flag_i,
    if_prefetch_if.master        ibus,
    output logic                 inst_valid_o,
    output logic [31:0]          inst_o,
    output logic [31:0]          inst_addr_o
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]          perf_starve_o,
    output logic [31:0]          perf_discard_o
`endif
);

    localparam int CW = $clog2(DEPTH);
    localparam int SW = CW + 2;

    logic [31:0]   r_pc;
    logic [31:0]   r_ret_addr;
    logic [CW:0]   r_outstanding;
    logic [CW:0]   r_discard;

    logic [CW:0]   w_count;
    logic [CW:0]   w_outstanding_nxt;
    logic [SW-1:0] w_credit_used;
    logic          w_empty, w_req, w_accept, w_drop, w_push, w_valid, w_pop;
    fetch_entry_t  w_head, w_push_entry;

    // Outstanding counts every in-flight read, including ones already marked for discard.
    assign w_credit_used = SW'(w_count) + SW'(r_outstanding);
    assign w_req         = !rst && !jump_flag_i && (w_credit_used < SW'(DEPTH));
    assign w_accept      = w_req && ibus.ibus_gnt;
    assign w_drop        = ibus.ibus_rvalid && (jump_flag_i || (r_discard != '0));
    assign w_push        = ibus.ibus_rvalid && !w_drop && !rst;
    assign w_valid       = !rst && !w_empty && !jump_flag_i;
    assign w_pop         = w_valid && (pause_flag_i == PAUSE_NONE);
    assign w_push_entry  = '{addr: r_ret_addr, inst: ibus.ibus_rdata};

    assign ibus.ibus_req  = w_req;
    assign ibus.ibus_addr = r_pc;

    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? w_head.inst : INST_NOP;
    assign inst_addr_o  = w_valid ? w_head.addr : ZERO_WORD;

    // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_accept && !ibus.ibus_rvalid)      w_outstanding_nxt = r_outstanding + 1'b1;
        else if (!w_accept && ibus.ibus_rvalid) w_outstanding_nxt = r_outstanding - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_ret_addr    <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (jump_flag_i) begin
                r_pc       <= jump_addr_i;
                r_ret_addr <= jump_addr_i;
                r_discard  <= w_outstanding_nxt;
            end else begin
                if (w_accept) r_pc       <= r_pc + 32'd4;
                if (w_push)   r_ret_addr <= r_ret_addr + 32'd4;
                if (w_drop)   r_discard  <= r_discard - 1'b1;
            end
        end
    end

    if_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (jump_flag_i),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] r_perf_starve;
    logic [31:0] r_perf_discard;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_starve  <= '0;
            r_perf_discard <= '0;
        end else begin
            if (w_empty && (pause_flag_i == PAUSE_NONE)) r_perf_starve <= sat_inc32(r_perf_starve);
            if (w_drop) r_perf_discard <= sat_inc32(r_perf_discard);
        end
    end

    assign perf_starve_o  = r_perf_starve;
    assign perf_discard_o = r_perf_discard;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Scoreboard bench for if_prefetch: a bus memory model, a stimulus thread that queues the
// expected fetch addresses, and a monitor that compares every presented instruction.
`timescale 1ns/1ps
module tb_if_prefetch;
    import if_prefetch_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic [2:0]  pause_flag_i = 3'b000;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_starve_o;
    logic [31:0] perf_discard_o;
`endif

    if_prefetch_if ibus ();

    always #5 clk = ~clk;

    if_prefetch #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag_i),
        .jump_addr_i  (jump_addr_i),
        .pause_flag_i (pause_flag_i),
        .ibus         (ibus),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o)
`ifdef IF_PREFETCH_PERF_EN
        ,
        .perf_starve_o  (perf_starve_o),
        .perf_discard_o (perf_discard_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;

    pend_t pend_q[$];
    int    cyc      = 0;
    int    lat_min  = 0;
    int    lat_max  = 0;
    bit    rand_gnt = 1'b0;

    initial begin
        bit          acc;
        bit          rst_s;
        logic [31:0] a;
        ibus.ibus_gnt    = 1'b1;
        ibus.ibus_rvalid = 1'b0;
        ibus.ibus_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            acc   = ibus.ibus_req && ibus.ibus_gnt;
            a     = ibus.ibus_addr;
            rst_s = rst;
            @(posedge clk);
            #1;
            cyc++;
            if (rst_s) pend_q.delete();
            else if (acc) pend_q.push_back('{addr: a, ready: cyc + int'($urandom_range(lat_max, lat_min))});
            if (!rst_s && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
                ibus.ibus_rvalid = 1'b1;
                ibus.ibus_rdata  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                ibus.ibus_rvalid = 1'b0;
                ibus.ibus_rdata  = 32'hDEAD_BEEF;
            end
            ibus.ibus_gnt = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // ---------------- scoreboard + monitor ----------------
    logic [31:0] exp_q[$];

    task automatic expect_seq(input logic [31:0] start, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    initial begin
        logic        prev_req  = 1'b0;
        logic        prev_gnt  = 1'b0;
        logic [31:0] prev_addr = 32'h0;
        forever begin
            @(negedge clk);
            if (inst_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("valid_with_empty_scoreboard", 32'(inst_valid_o), 32'h0);
                end else begin
                    check("inst_addr", inst_addr_o, exp_q[0]);
                    check("inst_data", inst_o, mem_word(exp_q[0]));
                    if (pause_flag_i == 3'b000) begin
                        void'(exp_q.pop_front());
                        n_pops++;
                    end
                end
            end else begin
                check("nop_when_invalid", inst_o, INST_NOP);
            end
            if (!rst && prev_req && !prev_gnt && ibus.ibus_req)
                check("ibus_addr_stable", ibus.ibus_addr, prev_addr);
            prev_req  = ibus.ibus_req;
            prev_gnt  = ibus.ibus_gnt;
            prev_addr = ibus.ibus_addr;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int start = n_pops;
        int i     = 0;
        while ((n_pops - start) < target && i < budget) begin
            tick(1);
            i++;
        end
        check(name, 32'(n_pops - start), 32'(target));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int p0;

        // Reset state and zero-wait streaming.
        tick(2);
        @(negedge clk);
        check("rst_valid", 32'(inst_valid_o), 32'h0);
        check("rst_req", 32'(ibus.ibus_req), 32'h0);
        check("rst_inst", inst_o, INST_NOP);
        check("rst_inst_addr", inst_addr_o, 32'h0);
        @(posedge clk);
        #1;
        expect_seq(32'h0, 2048);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", 32'(ibus.ibus_req), 32'h1);
        check("first_req_addr", ibus.ibus_addr, 32'h0);
        @(negedge clk);
        check("valid_cycle1", 32'(inst_valid_o), 32'h0);
        @(negedge clk);
        check("valid_cycle2", 32'(inst_valid_o), 32'h1);
        @(posedge clk);
        #1;
        p0 = n_pops;
        tick(10);
        check("zero_wait_throughput", 32'(n_pops - p0), 32'd10);

        // Pause: output frozen, FIFO fills, requests stop, resume in order.
        p0 = n_pops;
        pause_flag_i = 3'b010;
        tick(4);
        @(negedge clk);
        check("pause_full_no_req", 32'(ibus.ibus_req), 32'h0);
        check("pause_no_pop", 32'(n_pops - p0), 32'h0);
        @(posedge clk);
        #1;
        pause_flag_i = 3'b000;
        wait_pops(20, 100, "pause_resume_progress");

        // Jump while paused with a full FIFO.
        pause_flag_i = 3'b001;
        tick(6);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h200;
        expect_seq(32'h200, 2048);
        @(negedge clk);
        check("pjump_valid_low", 32'(inst_valid_o), 32'h0);
        check("pjump_req_low", 32'(ibus.ibus_req), 32'h0);
        @(posedge clk);
        #1;
        jump_flag_i = 1'b0;
        tick(5);
        @(negedge clk);
        check("pjump_head_is_target", inst_addr_o, 32'h200);
        @(posedge clk);
        #1;
        pause_flag_i = 3'b000;
        wait_pops(10, 50, "pjump_resume_progress");

        // Random grant and return latency, random pauses, no jumps.
        p0 = n_pops;
        rand_gnt = 1'b1;
        lat_min  = 0;
        lat_max  = 3;
        for (int i = 0; i < 1000; i++) begin
            pause_flag_i = ($urandom_range(0, 3) == 0) ? 3'b100 : 3'b000;
            tick(1);
        end
        pause_flag_i = 3'b000;
        rand_gnt = 1'b0;
        lat_max  = 0;
        check("random_progress", 32'((n_pops - p0) > 100), 32'h1);
        wait_pops(10, 100, "random_drain_progress");

        // Reset mid-burst: outputs drop, refetch from RESET_PC.
        rst = 1'b1;
        expect_seq(32'h0, 2048);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_valid", 32'(inst_valid_o), 32'h0);
        check("rst_mid_req", 32'(ibus.ibus_req), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_fifo_cleared", 32'(inst_valid_o), 32'h0);
        check("rst_refetch_req", 32'(ibus.ibus_req), 32'h1);
        check("rst_refetch_addr", ibus.ibus_addr, 32'h0);
        @(posedge clk);
        #1;
        wait_pops(8, 50, "rst_refetch_progress");

        // Jump with two reads outstanding on a slow memory: both responses dropped.
        rst = 1'b1;
        tick(2);
        lat_min = 5;
        lat_max = 5;
        expect_seq(32'h100, 2048);
        rst = 1'b0;
        tick(2);
        jump_flag_i = 1'b1;
        jump_addr_i = 32'h100;
        @(negedge clk);
        check("jump_valid_low", 32'(inst_valid_o), 32'h0);
        check("jump_req_low", 32'(ibus.ibus_req), 32'h0);
        @(posedge clk);
        #1;
        jump_flag_i = 1'b0;
        @(negedge clk);
        check("jump_target_req_addr", ibus.ibus_addr, 32'h100);
        @(posedge clk);
        #1;
        wait_pops(6, 80, "jump_target_progress");
`ifdef IF_PREFETCH_PERF_EN
        check("perf_discard", perf_discard_o, 32'd2);
`endif

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
